// File: rtl/mips_uart_tx_arbiter.sv
// Packet-granular round-robin arbiter that shares one UART transmitter between
// two word streams, serializing each granted word MSB byte first.
module mips_uart_tx_arbiter #(
    parameter int unsigned NBITS     = 32,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req0_valid,
    input  logic [NBITS-1:0]     i_req0_word,
    input  logic                 i_req0_last,
    output logic                 o_req0_ready,
    input  logic                 i_req1_valid,
    input  logic [NBITS-1:0]     i_req1_word,
    input  logic                 i_req1_last,
    output logic                 o_req1_ready,
    input  logic                 i_uart_tx_done,
    output logic [DATA_BITS-1:0] o_uart_tx_data,
    output logic                 o_uart_tx_start,
    output logic [1:0]           o_grant,
    output logic                 o_busy
);
    localparam int unsigned BYTES_PER_WORD = NBITS / DATA_BITS;
    localparam int unsigned CNT_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD      = 3'd1;
    localparam logic [2:0] ST_SEND      = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK  = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;

    logic [2:0]       r_state,    w_state_nx;
    logic             r_ptr,      w_ptr_nx;
    logic [1:0]       r_grant,    w_grant_nx;
    logic [NBITS-1:0] r_shift,    w_shift_nx;
    logic [CNT_W-1:0] r_byte_cnt, w_byte_cnt_nx;
    logic             r_last,     w_last_nx;

    logic             w_gnt_valid;
    logic [NBITS-1:0] w_gnt_word;
    logic             w_gnt_last;
    logic             w_start;

    // Mux of the currently granted requester's stream.
    assign w_gnt_valid = r_grant[1] ? i_req1_valid : (r_grant[0] & i_req0_valid);
    assign w_gnt_word  = r_grant[1] ? i_req1_word  : i_req0_word;
    assign w_gnt_last  = r_grant[1] ? i_req1_last  : i_req0_last;
    assign w_start     = (r_state == ST_SEND) & i_uart_tx_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ptr      <= 1'b0;
            r_grant    <= 2'b00;
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_last     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_ptr      <= w_ptr_nx;
            r_grant    <= w_grant_nx;
            r_shift    <= w_shift_nx;
            r_byte_cnt <= w_byte_cnt_nx;
            r_last     <= w_last_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_ptr_nx      = r_ptr;
        w_grant_nx    = r_grant;
        w_shift_nx    = r_shift;
        w_byte_cnt_nx = r_byte_cnt;
        w_last_nx     = r_last;
        case (r_state)
            ST_IDLE: begin
                // The pointed-to requester wins when both are valid.
                if (i_req0_valid | i_req1_valid) begin
                    w_grant_nx = (r_ptr ? !i_req1_valid : i_req0_valid) ? 2'b01 : 2'b10;
                    w_state_nx = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_gnt_valid) begin
                    w_shift_nx    = w_gnt_word;
                    w_last_nx     = w_gnt_last;
                    w_byte_cnt_nx = '0;
                    w_state_nx    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_start) begin
                    w_state_nx = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (!i_uart_tx_done) begin
                    w_state_nx = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (i_uart_tx_done) begin
                    if (r_byte_cnt < LAST_BYTE) begin
                        w_shift_nx    = {r_shift[NBITS-DATA_BITS-1:0], DATA_BITS'(0)};
                        w_byte_cnt_nx = r_byte_cnt + CNT_W'(1);
                        w_state_nx    = ST_SEND;
                    end else if (r_last) begin
                        w_ptr_nx   = ~r_grant[1];
                        w_grant_nx = 2'b00;
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_state_nx = ST_LOAD;
                    end
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_grant_nx = 2'b00;
            end
        endcase
    end

    assign o_req0_ready    = (r_state == ST_LOAD) & r_grant[0] & i_req0_valid;
    assign o_req1_ready    = (r_state == ST_LOAD) & r_grant[1] & i_req1_valid;
    assign o_uart_tx_data  = r_shift[NBITS-1 -: DATA_BITS];
    assign o_uart_tx_start = w_start;
    assign o_grant         = r_grant;
    assign o_busy          = (r_state != ST_IDLE);
endmodule

// File: tb/tb_mips_uart_tx_arbiter.sv
// Self-checking bench for mips_uart_tx_arbiter: cycle vectors, directed packet
// scenarios and randomized packets checked against a round-robin byte-order model.
module tb_mips_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req0_valid = 1'b0, i_req0_last = 1'b0, o_req0_ready;
    logic [31:0] i_req0_word = '0;
    logic        i_req1_valid = 1'b0, i_req1_last = 1'b0, o_req1_ready;
    logic [31:0] i_req1_word = '0;
    logic        i_uart_tx_done = 1'b1;
    logic [7:0]  o_uart_tx_data;
    logic        o_uart_tx_start;
    logic [1:0]  o_grant;
    logic        o_busy;

    mips_uart_tx_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req0_valid(i_req0_valid), .i_req0_word(i_req0_word), .i_req0_last(i_req0_last),
        .o_req0_ready(o_req0_ready),
        .i_req1_valid(i_req1_valid), .i_req1_word(i_req1_word), .i_req1_last(i_req1_last),
        .o_req1_ready(o_req1_ready),
        .i_uart_tx_done(i_uart_tx_done), .o_uart_tx_data(o_uart_tx_data),
        .o_uart_tx_start(o_uart_tx_start), .o_grant(o_grant), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        logic        l;
        int          gap;
    } wd_t;

    typedef struct {
        logic       v0;
        logic       done;
        logic       e_rdy0;
        logic       e_start;
        logic [1:0] e_grant;
        logic       e_busy;
        logic [7:0] e_data;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    wd_t        q[2][$];
    wd_t        m[2][$];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         mptr = 0;
    int         rdy_cnt[2];
    bit         front_new[2];
    int         gap_c[2];
    bit         go = 0, auto_en = 0;
    int         u_busy = 0, u_hold = 1;
    bit         start_pend = 0, prev_start = 0, prev_done = 1, done_rose = 0;
    logic [1:0] watch_grant = 2'b00;
    int         grant_err = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_word(int r, logic [31:0] w, logic l, int gap);
        wd_t e;
        e.w = w; e.l = l; e.gap = gap;
        q[r].push_back(e);
        m[r].push_back(e);
    endtask

    // Reference: whole packets in round-robin order, each word MSB byte first.
    task automatic build_exp();
        wd_t w;
        int  o;
        while (m[0].size() > 0 || m[1].size() > 0) begin
            o = (m[mptr].size() > 0) ? mptr : 1 - mptr;
            do begin
                w = m[o].pop_front();
                for (int b = 0; b < 4; b++) exp_q.push_back(w.w[31 - 8*b -: 8]);
            end while (!w.l && m[o].size() > 0);
            mptr = 1 - o;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        go = 0; auto_en = 0;
        for (int r = 0; r < 2; r++) begin
            q[r] = {}; m[r] = {};
            rdy_cnt[r] = 0; front_new[r] = 1; gap_c[r] = 0;
        end
        got_q = {}; exp_q = {}; mptr = 0;
        u_busy = 0; start_pend = 0; prev_start = 0; watch_grant = 2'b00; grant_err = 0;
        i_req0_valid = 0; i_req0_word = '0; i_req0_last = 0;
        i_req1_valid = 0; i_req1_word = '0; i_req1_last = 0;
        i_uart_tx_done = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_grant", 64'(o_grant), 64'(0));
        chk("reset_start", 64'(o_uart_tx_start), 64'(0));
        chk("reset_busy", 64'(o_busy), 64'(0));
        chk("reset_ready", 64'({o_req0_ready, o_req1_ready}), 64'(0));
        chk("reset_data", 64'(o_uart_tx_data), 64'(0));
        reset = 1'b0;
    endtask

    // Sample DUT outputs mid-cycle and act as UART/requester monitors.
    task automatic step_neg();
        @(negedge clk);
        done_rose = i_uart_tx_done && !prev_done;
        prev_done = i_uart_tx_done;
        if (reset || !auto_en) begin
            prev_start = 0;
            return;
        end
        if (o_uart_tx_start) begin
            chk("start_while_uart_busy", 64'(i_uart_tx_done), 64'(1));
            chk("start_width", 64'(prev_start), 64'(0));
            got_q.push_back(o_uart_tx_data);
            start_pend = 1;
        end
        prev_start = o_uart_tx_start;
        if (watch_grant != 2'b00 && o_busy && o_grant != watch_grant) grant_err++;
        if (o_req0_ready) begin
            chk("ready0_owner", 64'(o_grant), 64'(2'b01));
            if (q[0].size() > 0) void'(q[0].pop_front());
            rdy_cnt[0]++; front_new[0] = 1;
        end
        if (o_req1_ready) begin
            chk("ready1_owner", 64'(o_grant), 64'(2'b10));
            if (q[1].size() > 0) void'(q[1].pop_front());
            rdy_cnt[1]++; front_new[1] = 1;
        end
    endtask

    // Drive UART done and requester streams just after the active edge.
    task automatic step_pos();
        logic        dv[2];
        logic [31:0] dw[2];
        logic        dl[2];
        @(posedge clk);
        #1;
        if (!auto_en || reset) return;
        if (start_pend) begin
            u_busy = u_hold; start_pend = 0;
        end else if (u_busy > 0) begin
            u_busy--;
        end
        i_uart_tx_done = (u_busy == 0);
        for (int r = 0; r < 2; r++) begin
            dv[r] = 1'b0; dw[r] = '0; dl[r] = 1'b0;
            if (go && q[r].size() > 0) begin
                if (front_new[r]) begin
                    gap_c[r] = q[r][0].gap; front_new[r] = 0;
                end
                if (gap_c[r] > 0) gap_c[r]--;
                else begin
                    dv[r] = 1'b1; dw[r] = q[r][0].w; dl[r] = q[r][0].l;
                end
            end
        end
        i_req0_valid = dv[0]; i_req0_word = dw[0]; i_req0_last = dl[0];
        i_req1_valid = dv[1]; i_req1_word = dw[1]; i_req1_last = dl[1];
    endtask

    task automatic step();
        step_neg();
        step_pos();
    endtask

    task automatic run_drain(string name, int budget);
        int n = 0;
        step();
        while (!(q[0].size() == 0 && q[1].size() == 0 && got_q.size() >= exp_q.size() && !o_busy)
               && n < budget) begin
            step();
            n++;
        end
        chk({name, "_timeout"}, 64'(n < budget), 64'(1));
    endtask

    task automatic compare_stream(string name);
        chk({name, "_byte_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_byte%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
        got_q = {}; exp_q = {};
    endtask

    vec_t tbl[15];

    initial begin
        int  n;
        bit  hit;
        int  busy_drop;
        int  words0, words1;

        // DEADBEEF word with done held low through the first SEND cycles.
        tbl = '{
            '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00},
            '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00},
            '{1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 8'h00},
            '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 8'hDE},
            '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 8'hDE},
            '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 8'hDE},
            '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 8'hDE},
            '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 8'hDE},
            '{1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 8'hDE},
            '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 8'hDE},
            '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 8'hDE},
            '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 8'hDE},
            '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 8'hDE},
            '{1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 8'hAD},
            '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 8'hAD}
        };

        do_reset();
        for (int i = 0; i < 15; i++) begin
            i_req0_valid = tbl[i].v0; i_req0_word = 32'hDEADBEEF; i_req0_last = 1'b1;
            i_req1_valid = 1'b0;      i_req1_word = '0;           i_req1_last = 1'b0;
            i_uart_tx_done = tbl[i].done;
            @(negedge clk);
            chk($sformatf("vec%0d_ready0", i), 64'(o_req0_ready), 64'(tbl[i].e_rdy0));
            chk($sformatf("vec%0d_ready1", i), 64'(o_req1_ready), 64'(0));
            chk($sformatf("vec%0d_start", i), 64'(o_uart_tx_start), 64'(tbl[i].e_start));
            chk($sformatf("vec%0d_grant", i), 64'(o_grant), 64'(tbl[i].e_grant));
            chk($sformatf("vec%0d_busy", i), 64'(o_busy), 64'(tbl[i].e_busy));
            chk($sformatf("vec%0d_data", i), 64'(o_uart_tx_data), 64'(tbl[i].e_data));
            @(posedge clk);
            #1;
        end

        // Single word, slow UART, then both requesters with pointer at req1.
        do_reset();
        auto_en = 1; u_hold = 10; watch_grant = 2'b01;
        push_word(0, 32'hDEADBEEF, 1'b1, 0);
        build_exp();
        go = 1;
        run_drain("t1", 2000);
        compare_stream("t1");
        chk("t1_ready0_pulses", 64'(rdy_cnt[0]), 64'(1));
        chk("t1_grant_err", 64'(grant_err), 64'(0));
        watch_grant = 2'b00; u_hold = 2;
        push_word(0, 32'h11111111, 1'b0, 0); push_word(0, 32'h22222222, 1'b1, 0);
        push_word(1, 32'hAAAAAAAA, 1'b0, 0); push_word(1, 32'hBBBBBBBB, 1'b1, 0);
        build_exp();
        run_drain("t1b", 2000);
        compare_stream("t1b_req1_first");

        // Simultaneous requests straight after reset: req0 packet first.
        do_reset();
        auto_en = 1; u_hold = 3;
        push_word(0, 32'h11111111, 1'b0, 0); push_word(0, 32'h22222222, 1'b1, 0);
        push_word(1, 32'hAAAAAAAA, 1'b0, 0); push_word(1, 32'hBBBBBBBB, 1'b1, 0);
        build_exp();
        go = 1;
        run_drain("t2", 2000);
        compare_stream("t2");
        chk("t2_ready_counts", 64'({rdy_cnt[0], rdy_cnt[1]}), 64'({32'd2, 32'd2}));

        // Req1 stalls mid-packet while req0 waits: the packet is never abandoned.
        do_reset();
        auto_en = 1; u_hold = 1;
        push_word(1, 32'hA1A2A3A4, 1'b0, 0); push_word(1, 32'hB1B2B3B4, 1'b1, 20);
        go = 1;
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            step();
            hit = (rdy_cnt[1] == 1);
        end
        chk("t3_req1_granted", 64'(hit), 64'(1));
        push_word(0, 32'hC1C2C3C4, 1'b1, 0);
        mptr = 1;  // req1 was granted alone before req0 arrived
        build_exp();
        repeat (15) step();
        chk("t3_grant_held", 64'(o_grant), 64'(2'b10));
        chk("t3_no_req0_ready", 64'(rdy_cnt[0]), 64'(0));
        chk("t3_busy_in_gap", 64'(o_busy), 64'(1));
        run_drain("t3", 2000);
        compare_stream("t3");

        // Reset during the third byte, then a fresh word from its MSB.
        do_reset();
        auto_en = 1; u_hold = 3;
        push_word(0, 32'h12345678, 1'b1, 0);
        go = 1;
        hit = 0;
        for (int i = 0; i < 200; i++) begin
            step_neg();
            if (got_q.size() == 3) begin
                hit = 1;
                break;
            end
            step_pos();
        end
        chk("t5_reached_byte3", 64'(hit), 64'(1));
        chk("t5_start_before_reset", 64'(o_uart_tx_start), 64'(1));
        #1 reset = 1'b1;
        #1;
        chk("t5_start_at_reset", 64'(o_uart_tx_start), 64'(0));
        chk("t5_grant_at_reset", 64'(o_grant), 64'(0));
        chk("t5_busy_at_reset", 64'(o_busy), 64'(0));
        if (got_q.size() == 3) chk("t5_partial", 64'({got_q[0], got_q[1], got_q[2]}), 64'(24'h123456));
        do_reset();
        auto_en = 1; u_hold = 3;
        push_word(0, 32'hCAFEF00D, 1'b1, 0);
        build_exp();
        go = 1;
        run_drain("t5", 2000);
        compare_stream("t5");

        // 32-word packet: busy across all words, drops one cycle after last done.
        do_reset();
        auto_en = 1; u_hold = 1;
        for (int i = 0; i < 32; i++) push_word(0, 32'(i), i == 31, 0);
        build_exp();
        go = 1;
        n = 0;
        while (rdy_cnt[0] == 0 && n < 50) begin step(); n++; end
        busy_drop = 0;
        n = 0;
        while (got_q.size() < 128 && n < 3000) begin
            step();
            if (!o_busy) busy_drop++;
            n++;
        end
        chk("t6_reached_128", 64'(got_q.size()), 64'(128));
        hit = 0;
        for (int i = 0; i < 50; i++) begin
            step_neg();
            if (done_rose) begin
                hit = 1;
                break;
            end
            if (!o_busy) busy_drop++;
            step_pos();
        end
        chk("t6_final_done_seen", 64'(hit), 64'(1));
        chk("t6_busy_at_final_done", 64'(o_busy), 64'(1));
        step_pos();
        step_neg();
        chk("t6_busy_after_final_done", 64'(o_busy), 64'(0));
        step_pos();
        chk("t6_busy_drops", 64'(busy_drop), 64'(0));
        chk("t6_ready0_pulses", 64'(rdy_cnt[0]), 64'(32));
        compare_stream("t6");

        // Randomized packet mixes, pointer carried across rounds.
        for (int rnd = 0; rnd < 8; rnd++) begin
            u_hold = $urandom_range(1, 6);
            words0 = rdy_cnt[0]; words1 = rdy_cnt[1];
            for (int r = 0; r < 2; r++) begin
                int npk = $urandom_range(0, 3);
                if (r == 1 && q[0].size() == 0 && npk == 0) npk = 1;
                for (int p = 0; p < npk; p++) begin
                    int len = $urandom_range(1, 4);
                    for (int i = 0; i < len; i++) begin
                        push_word(r, $urandom, i == len - 1, (i == 0) ? 0 : $urandom_range(0, 6));
                        if (r == 0) words0++; else words1++;
                    end
                end
            end
            build_exp();
            run_drain($sformatf("rnd%0d", rnd), 5000);
            compare_stream($sformatf("rnd%0d", rnd));
            chk($sformatf("rnd%0d_ready0_total", rnd), 64'(rdy_cnt[0]), 64'(words0));
            chk($sformatf("rnd%0d_ready1_total", rnd), 64'(rdy_cnt[1]), 64'(words1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
